// File: rtl/lsu_oram_store_pkg.sv
// Shared LSU definitions for the store-to-ORAM path: geometry constants,
// store FSM encoding and the row-count type.
package lsu_oram_store_pkg;

  localparam int LSU_ROW_NUM = 16;
  localparam int LSU_ROW_W   = 128;
  localparam int LSU_ADDR_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } st_state_e;

  typedef logic [3:0] row_cnt_t;

endpackage

// File: rtl/lsu_oram_store_if.sv
// ORAM write-port bundle driven by the LSU store path towards the ORAM macro.
interface lsu_oram_store_if #(
  parameter int ADDR_W = 8,
  parameter int ROW_W  = 128
);

  logic              lsu_oram_cen;
  logic              lsu_oram_wen;
  logic [ADDR_W-1:0] lsu_oram_addr;
  logic [ROW_W-1:0]  lsu_oram_din;
  logic              lsu_st_done;

  modport master (
    output lsu_oram_cen,
    output lsu_oram_wen,
    output lsu_oram_addr,
    output lsu_oram_din,
    output lsu_st_done
  );

  modport slave (
    input lsu_oram_cen,
    input lsu_oram_wen,
    input lsu_oram_addr,
    input lsu_oram_din,
    input lsu_st_done
  );

endinterface

// File: rtl/lsu_oram_store.sv
// Store-to-ORAM path: accepts an IDU command, captures the 16 MXU result rows
// in one cycle, then writes the requested rows to consecutive ORAM entries.
module lsu_oram_store
  import lsu_oram_store_pkg::*;
#(
  parameter int ROW_NUM = LSU_ROW_NUM,
  parameter int ROW_W   = LSU_ROW_W,
  parameter int ADDR_W  = LSU_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idu_lsu_vld,
  input  logic             idu_lsu_st_oram,
  input  logic [11:0]      idu_lsu_ld_st_addr,
  input  logic [7:0]       idu_lsu_num,
  output logic             lsu_idu_st_rdy,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row0_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row1_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row2_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row3_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row4_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row5_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row6_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row7_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row8_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row9_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row10_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row11_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row12_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row13_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row14_data,
  input  logic [ROW_W-1:0] mxu_lsu_int8_row15_data,
  input  logic             mxu_lsu_data_rdy,
  lsu_oram_store_if.master oram
);

  st_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  row_cnt_t          last_q;
  row_cnt_t          cnt_q;
  logic              accept;
  logic              capture;
  logic              last_write;
  logic [ROW_W-1:0]  mxu_rows [ROW_NUM];
  logic [ROW_W-1:0]  row_buf  [ROW_NUM];

  // Byte-offset bits of the address and the upper row-count bits carry no meaning here.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{idu_lsu_ld_st_addr[3:0], idu_lsu_num[7:4]};

  assign mxu_rows[0]  = mxu_lsu_int8_row0_data;
  assign mxu_rows[1]  = mxu_lsu_int8_row1_data;
  assign mxu_rows[2]  = mxu_lsu_int8_row2_data;
  assign mxu_rows[3]  = mxu_lsu_int8_row3_data;
  assign mxu_rows[4]  = mxu_lsu_int8_row4_data;
  assign mxu_rows[5]  = mxu_lsu_int8_row5_data;
  assign mxu_rows[6]  = mxu_lsu_int8_row6_data;
  assign mxu_rows[7]  = mxu_lsu_int8_row7_data;
  assign mxu_rows[8]  = mxu_lsu_int8_row8_data;
  assign mxu_rows[9]  = mxu_lsu_int8_row9_data;
  assign mxu_rows[10] = mxu_lsu_int8_row10_data;
  assign mxu_rows[11] = mxu_lsu_int8_row11_data;
  assign mxu_rows[12] = mxu_lsu_int8_row12_data;
  assign mxu_rows[13] = mxu_lsu_int8_row13_data;
  assign mxu_rows[14] = mxu_lsu_int8_row14_data;
  assign mxu_rows[15] = mxu_lsu_int8_row15_data;

  assign accept     = (state_q == ST_IDLE) && idu_lsu_vld && idu_lsu_st_oram;
  assign capture    = (state_q == ST_WAIT) && mxu_lsu_data_rdy;
  assign last_write = (state_q == ST_WRITE) && (cnt_q == last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)     state_d = ST_WAIT;
      ST_WAIT:  if (capture)    state_d = ST_WRITE;
      ST_WRITE: if (last_write) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Address and data are forced to zero outside WRITE so reset values are defined
  // without resetting the row buffer.
  always_comb begin
    lsu_idu_st_rdy     = (state_q == ST_IDLE);
    oram.lsu_oram_cen  = 1'b0;
    oram.lsu_oram_wen  = 1'b0;
    oram.lsu_oram_addr = '0;
    oram.lsu_oram_din  = '0;
    oram.lsu_st_done   = 1'b0;
    if (state_q == ST_WRITE) begin
      oram.lsu_oram_cen  = 1'b1;
      oram.lsu_oram_wen  = 1'b1;
      oram.lsu_oram_addr = base_q + ADDR_W'(cnt_q);
      oram.lsu_oram_din  = row_buf[cnt_q];
      oram.lsu_st_done   = last_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      last_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        base_q <= idu_lsu_ld_st_addr[11:4];
        last_q <= idu_lsu_num[3:0];
      end
      if (capture)
        cnt_q <= '0;
      else if ((state_q == ST_WRITE) && !last_write)
        cnt_q <= cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned i = 0; i < ROW_NUM; i++)
        row_buf[i] <= mxu_rows[i];
    end
  end

endmodule

// File: tb/tb_lsu_oram_store.sv
// Directed self-checking bench for lsu_oram_store.
module tb_lsu_oram_store;

  logic         clk;
  logic         rst_n;
  logic         idu_lsu_vld;
  logic         idu_lsu_st_oram;
  logic [11:0]  idu_lsu_ld_st_addr;
  logic [7:0]   idu_lsu_num;
  logic         lsu_idu_st_rdy;
  logic         mxu_lsu_data_rdy;
  logic [127:0] tb_rows [16];

  int n_checks;
  int n_fail;

  lsu_oram_store_if #(.ADDR_W(8), .ROW_W(128)) ifc ();

  lsu_oram_store #(.ROW_NUM(16), .ROW_W(128), .ADDR_W(8)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .idu_lsu_vld             (idu_lsu_vld),
    .idu_lsu_st_oram         (idu_lsu_st_oram),
    .idu_lsu_ld_st_addr      (idu_lsu_ld_st_addr),
    .idu_lsu_num             (idu_lsu_num),
    .lsu_idu_st_rdy          (lsu_idu_st_rdy),
    .mxu_lsu_int8_row0_data  (tb_rows[0]),
    .mxu_lsu_int8_row1_data  (tb_rows[1]),
    .mxu_lsu_int8_row2_data  (tb_rows[2]),
    .mxu_lsu_int8_row3_data  (tb_rows[3]),
    .mxu_lsu_int8_row4_data  (tb_rows[4]),
    .mxu_lsu_int8_row5_data  (tb_rows[5]),
    .mxu_lsu_int8_row6_data  (tb_rows[6]),
    .mxu_lsu_int8_row7_data  (tb_rows[7]),
    .mxu_lsu_int8_row8_data  (tb_rows[8]),
    .mxu_lsu_int8_row9_data  (tb_rows[9]),
    .mxu_lsu_int8_row10_data (tb_rows[10]),
    .mxu_lsu_int8_row11_data (tb_rows[11]),
    .mxu_lsu_int8_row12_data (tb_rows[12]),
    .mxu_lsu_int8_row13_data (tb_rows[13]),
    .mxu_lsu_int8_row14_data (tb_rows[14]),
    .mxu_lsu_int8_row15_data (tb_rows[15]),
    .mxu_lsu_data_rdy        (mxu_lsu_data_rdy),
    .oram                    (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] row_val(input logic [7:0] seed, input int i);
    logic [7:0] b;
    b = seed + 8'(i);
    return {16{b}};
  endfunction

  task automatic set_rows(input logic [7:0] seed);
    for (int i = 0; i < 16; i++) tb_rows[i] = row_val(seed, i);
  endtask

  // Caller sits on a negedge; the command is accepted at the following posedge.
  task automatic issue(input logic [11:0] a, input logic [7:0] n);
    idu_lsu_vld        = 1'b1;
    idu_lsu_st_oram    = 1'b1;
    idu_lsu_ld_st_addr = a;
    idu_lsu_num        = n;
    @(negedge clk);
    idu_lsu_vld        = 1'b0;
    idu_lsu_st_oram    = 1'b0;
    idu_lsu_ld_st_addr = 12'h000;
    idu_lsu_num        = 8'h00;
  endtask

  // Present rows for one edge, then scramble inputs so later reads must come from the buffer.
  task automatic pulse_rdy(input logic [7:0] seed);
    set_rows(seed);
    mxu_lsu_data_rdy = 1'b1;
    @(negedge clk);
    mxu_lsu_data_rdy = 1'b0;
    set_rows(seed + 8'h55);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (lsu_idu_st_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_st_rdy got %b want 1", lsu_idu_st_rdy); end
    n_checks++; if (ifc.lsu_oram_cen !== 1'b0) begin n_fail++; $display("FAIL reset_cen got %b want 0", ifc.lsu_oram_cen); end
    n_checks++; if (ifc.lsu_oram_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b want 0", ifc.lsu_oram_wen); end
    n_checks++; if (ifc.lsu_st_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", ifc.lsu_st_done); end
    n_checks++; if (ifc.lsu_oram_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", ifc.lsu_oram_addr); end
    n_checks++; if (ifc.lsu_oram_din !== 128'h0) begin n_fail++; $display("FAIL reset_din got %h want 0", ifc.lsu_oram_din); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    issue(12'h120, 8'd15);
    n_checks++; if (lsu_idu_st_rdy !== 1'b0) begin n_fail++; $display("FAIL basic_wait_rdy got %b want 0", lsu_idu_st_rdy); end
    repeat (2) @(negedge clk);
    n_checks++; if (ifc.lsu_oram_cen !== 1'b0) begin n_fail++; $display("FAIL basic_wait_cen got %b want 0", ifc.lsu_oram_cen); end
    pulse_rdy(8'h00);
    for (int k = 0; k < 16; k++) begin
      n_checks++; if (ifc.lsu_oram_cen !== 1'b1 || ifc.lsu_oram_wen !== 1'b1) begin n_fail++; $display("FAIL basic_en k=%0d got cen=%b wen=%b want 1/1", k, ifc.lsu_oram_cen, ifc.lsu_oram_wen); end
      n_checks++; if (ifc.lsu_oram_addr !== 8'(8'h12 + k)) begin n_fail++; $display("FAIL basic_addr k=%0d got %h want %h", k, ifc.lsu_oram_addr, 8'(8'h12 + k)); end
      n_checks++; if (ifc.lsu_oram_din !== row_val(8'h00, k)) begin n_fail++; $display("FAIL basic_din k=%0d got %h want %h", k, ifc.lsu_oram_din, row_val(8'h00, k)); end
      n_checks++; if (ifc.lsu_st_done !== (k == 15)) begin n_fail++; $display("FAIL basic_done k=%0d got %b want %b", k, ifc.lsu_st_done, (k == 15)); end
      @(negedge clk);
    end
    n_checks++; if (lsu_idu_st_rdy !== 1'b1) begin n_fail++; $display("FAIL basic_rdy_after got %b want 1", lsu_idu_st_rdy); end
    n_checks++; if (ifc.lsu_oram_cen !== 1'b0) begin n_fail++; $display("FAIL basic_cen_after got %b want 0", ifc.lsu_oram_cen); end
  endtask

  task automatic test_partial;
    issue(12'h34C, 8'hF2);
    pulse_rdy(8'h40);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (ifc.lsu_oram_cen !== 1'b1) begin n_fail++; $display("FAIL partial_cen k=%0d got %b want 1", k, ifc.lsu_oram_cen); end
      n_checks++; if (ifc.lsu_oram_addr !== 8'(8'h34 + k)) begin n_fail++; $display("FAIL partial_addr k=%0d got %h want %h", k, ifc.lsu_oram_addr, 8'(8'h34 + k)); end
      n_checks++; if (ifc.lsu_oram_din !== row_val(8'h40, k)) begin n_fail++; $display("FAIL partial_din k=%0d got %h want %h", k, ifc.lsu_oram_din, row_val(8'h40, k)); end
      n_checks++; if (ifc.lsu_st_done !== (k == 2)) begin n_fail++; $display("FAIL partial_done k=%0d got %b want %b", k, ifc.lsu_st_done, (k == 2)); end
      @(negedge clk);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (ifc.lsu_oram_cen !== 1'b0 || ifc.lsu_st_done !== 1'b0) begin n_fail++; $display("FAIL partial_idle c=%0d got cen=%b done=%b want 0/0", c, ifc.lsu_oram_cen, ifc.lsu_st_done); end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp_addr [4];
    exp_addr[0] = 8'hFF; exp_addr[1] = 8'h00; exp_addr[2] = 8'h01; exp_addr[3] = 8'h02;
    issue(12'hFF0, 8'd3);
    @(negedge clk);
    pulse_rdy(8'hC8);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (ifc.lsu_oram_addr !== exp_addr[k]) begin n_fail++; $display("FAIL wrap_addr k=%0d got %h want %h", k, ifc.lsu_oram_addr, exp_addr[k]); end
      n_checks++; if (ifc.lsu_oram_din !== row_val(8'hC8, k)) begin n_fail++; $display("FAIL wrap_din k=%0d got %h want %h", k, ifc.lsu_oram_din, row_val(8'hC8, k)); end
      n_checks++; if (ifc.lsu_st_done !== (k == 3)) begin n_fail++; $display("FAIL wrap_done k=%0d got %b want %b", k, ifc.lsu_st_done, (k == 3)); end
      @(negedge clk);
    end
  endtask

  task automatic test_spurious;
    // data_rdy in IDLE and a non-store command must both be ignored.
    pulse_rdy(8'h80);
    n_checks++; if (lsu_idu_st_rdy !== 1'b1 || ifc.lsu_oram_cen !== 1'b0) begin n_fail++; $display("FAIL spur_idle got rdy=%b cen=%b want 1/0", lsu_idu_st_rdy, ifc.lsu_oram_cen); end
    idu_lsu_vld = 1'b1; idu_lsu_st_oram = 1'b0; idu_lsu_ld_st_addr = 12'h500; idu_lsu_num = 8'd1;
    @(negedge clk);
    idu_lsu_vld = 1'b0;
    n_checks++; if (lsu_idu_st_rdy !== 1'b1) begin n_fail++; $display("FAIL spur_nonstore_rdy got %b want 1", lsu_idu_st_rdy); end
    // data_rdy in the accept cycle is not a capture.
    set_rows(8'h90);
    mxu_lsu_data_rdy = 1'b1;
    issue(12'h500, 8'd5);
    mxu_lsu_data_rdy = 1'b0;
    n_checks++; if (lsu_idu_st_rdy !== 1'b0 || ifc.lsu_oram_cen !== 1'b0) begin n_fail++; $display("FAIL spur_accept got rdy=%b cen=%b want 0/0", lsu_idu_st_rdy, ifc.lsu_oram_cen); end
    pulse_rdy(8'hA0);
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (ifc.lsu_oram_addr !== 8'(8'h50 + k)) begin n_fail++; $display("FAIL spur_addr k=%0d got %h want %h", k, ifc.lsu_oram_addr, 8'(8'h50 + k)); end
      n_checks++; if (ifc.lsu_oram_din !== row_val(8'hA0, k)) begin n_fail++; $display("FAIL spur_din k=%0d got %h want %h", k, ifc.lsu_oram_din, row_val(8'hA0, k)); end
      if (k == 2) begin set_rows(8'hB0); mxu_lsu_data_rdy = 1'b1; end
      @(negedge clk);
      mxu_lsu_data_rdy = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (lsu_idu_st_rdy !== 1'b1 || ifc.lsu_oram_cen !== 1'b0) begin n_fail++; $display("FAIL spur_after c=%0d got rdy=%b cen=%b want 1/0", c, lsu_idu_st_rdy, ifc.lsu_oram_cen); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    int writes_after;
    issue(12'h600, 8'd15);
    pulse_rdy(8'h10);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (ifc.lsu_oram_addr !== 8'(8'h60 + k) || ifc.lsu_oram_cen !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre k=%0d got addr=%h cen=%b want %h/1", k, ifc.lsu_oram_addr, ifc.lsu_oram_cen, 8'(8'h60 + k)); end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_checks++; if (ifc.lsu_oram_cen !== 1'b0) begin n_fail++; $display("FAIL rstmid_cen got %b want 0", ifc.lsu_oram_cen); end
    n_checks++; if (lsu_idu_st_rdy !== 1'b1) begin n_fail++; $display("FAIL rstmid_rdy got %b want 1", lsu_idu_st_rdy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    writes_after = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ifc.lsu_oram_cen === 1'b1) writes_after++;
    end
    n_checks++; if (writes_after !== 0) begin n_fail++; $display("FAIL rstmid_no_writes got %0d want 0", writes_after); end
    issue(12'h700, 8'd1);
    pulse_rdy(8'h20);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (ifc.lsu_oram_addr !== 8'(8'h70 + k)) begin n_fail++; $display("FAIL rstmid_fresh_addr k=%0d got %h want %h", k, ifc.lsu_oram_addr, 8'(8'h70 + k)); end
      n_checks++; if (ifc.lsu_oram_din !== row_val(8'h20, k)) begin n_fail++; $display("FAIL rstmid_fresh_din k=%0d got %h want %h", k, ifc.lsu_oram_din, row_val(8'h20, k)); end
      n_checks++; if (ifc.lsu_st_done !== (k == 1)) begin n_fail++; $display("FAIL rstmid_fresh_done k=%0d got %b want %b", k, ifc.lsu_st_done, (k == 1)); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    issue(12'h800, 8'd1);
    pulse_rdy(8'h30);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (ifc.lsu_oram_addr !== 8'(8'h80 + k)) begin n_fail++; $display("FAIL b2b_first_addr k=%0d got %h want %h", k, ifc.lsu_oram_addr, 8'(8'h80 + k)); end
      @(negedge clk);
    end
    n_checks++; if (lsu_idu_st_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy got %b want 1", lsu_idu_st_rdy); end
    issue(12'h930, 8'd2);
    n_checks++; if (lsu_idu_st_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got rdy=%b want 0", lsu_idu_st_rdy); end
    pulse_rdy(8'h60);
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (ifc.lsu_oram_addr !== 8'(8'h93 + k)) begin n_fail++; $display("FAIL b2b_addr k=%0d got %h want %h", k, ifc.lsu_oram_addr, 8'(8'h93 + k)); end
      n_checks++; if (ifc.lsu_oram_din !== row_val(8'h60, k)) begin n_fail++; $display("FAIL b2b_din k=%0d got %h want %h", k, ifc.lsu_oram_din, row_val(8'h60, k)); end
      n_checks++; if (ifc.lsu_st_done !== (k == 2)) begin n_fail++; $display("FAIL b2b_done k=%0d got %b want %b", k, ifc.lsu_st_done, (k == 2)); end
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n              = 1'b0;
    idu_lsu_vld        = 1'b0;
    idu_lsu_st_oram    = 1'b0;
    idu_lsu_ld_st_addr = 12'h000;
    idu_lsu_num        = 8'h00;
    mxu_lsu_data_rdy   = 1'b0;
    set_rows(8'h00);
    @(negedge clk);
    test_reset;
    test_basic;
    test_partial;
    test_wrap;
    test_spurious;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
